hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
Parametrised pipeline hazard controller between the F/D and D/X latches. It generates load-use stalls with a configurable bubble count and tracks one outstanding multi-cycle mult/div with a destination scoreboard. In non-blocking mode, independent instructions keep flowing while the multdiv unit works. It also adds a writeback-slot handshake and a timeout error that the previous combinational stall logic lacked.

Parameters:
REG_W, 5, register-index width; fields rd [26:22], rs [21:17], rt [16:12]
LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..3)
NONBLOCK_MD, 0, 0 = stall for the whole multdiv op; 1 = stall only on dependence
MD_TIMEOUT, 64, max cycles from md_start to multdiv_result_ready
ZERO_REG_EXEMPT, 1, 1 = hazards on register 0 are ignored

Ports:
clock  in  1  single clock; all state on rising edge
reset  in  1  asynchronous, active-low; asserted when 0
fd_ir  in  32  instruction in the F/D latch
dx_ir  in  32  instruction in the D/X latch
multdiv_result_ready  in  1  one-cycle pulse from the multdiv unit
select_stall  out  1  freeze PC and F/D, inject a nop into D/X
md_start  out  1  one-cycle start pulse to the multdiv unit
md_pending_rd  out  REG_W  latched destination of the outstanding op
md_wb_valid  out  1  multdiv result owns the writeback port this cycle
timeout_err  out  1  sticky; multdiv did not answer in time

Behaviour:
- Decode: opcode is [31:27]. lw = 01000; sw = 00111; R-type = 00000 with ALU op [6:2]. mult = 00110, div = 00111.
- Reset, async while low: state IDLE, load counter 0, timeout counter 0, md_pending_rd 0, timeout_err 0. All outputs 0 except select_stall, which is 1 while reset is low.
- Load-use hazard (combinational): dx is lw and dx_rd is nonzero (or ZERO_REG_EXEMPT=0), and either fd_rs==dx_rd or (fd_rt==dx_rd and fd is not sw).
  - On a hazard, stall that cycle and load the counter with LOAD_STALL_CYCLES-1.
  - Stall while the counter is nonzero; decrement each cycle.
  - A new hazard arriving while the counter is nonzero does not reload it.
- FSM states: IDLE, MD_BUSY, MD_WB, ERR.
  - IDLE: if dx is mult/div, md_start=1, latch md_pending_rd=dx_rd, clear the timeout counter, go to MD_BUSY.
  - MD_BUSY: the timeout counter increments each cycle.
    - multdiv_result_ready goes to MD_WB.
    - Else, counter reaching MD_TIMEOUT-1 goes to ERR.
    - Ready and timeout in the same cycle: ready wins.
  - MD_WB: md_wb_valid=1 for exactly one cycle, then IDLE. md_start may not fire in this cycle.
  - ERR: timeout_err=1 and select_stall=1 until reset.
  - multdiv_result_ready in IDLE or MD_WB is ignored.
- Stall, blocking mode (NONBLOCK_MD=0): select_stall = load-use | (dx is mult/div) | state≠IDLE.
- Stall, non-blocking mode (NONBLOCK_MD=1): select_stall = load-use | MD_WB | ERR | (MD_BUSY and fd is mult/div) | (MD_BUSY and fd reads or writes md_pending_rd (RAW/WAW; rd=0 exempt per ZERO_REG_EXEMPT)). The issue cycle itself does not stall.
- Back-to-back multdiv: a second mult/div reaching dx while state≠IDLE cannot occur, because fd stalls. If a bench forces it anyway, md_start is not pulsed.
- Latency: md_start is combinational in the issue cycle; md_wb_valid comes one cycle after ready; timeout_err sets one cycle after the expiring count.
- Widths: the timeout counter is clog2(MD_TIMEOUT)+1 bits; the load counter is 2 bits.

Decomposition:
- Package hazard_pkg: opcode constants (OP_RTYPE, OP_LW, OP_SW), ALU op constants (ALU_MULT, ALU_DIV), state enum, and the field-slice functions get_rd/get_rs/get_rt/get_opcode.
- One sub-module, hazard_md_fsm: the FSM, the timeout counter and md_pending_rd.
- Load-use detection and the stall merge stay in the top level.

Test Plan:
- Load-use (LOAD_STALL_CYCLES=2): dx=lw r5, fd=add r1,r5,r2 -> select_stall high for exactly 2 cycles; fd=sw r5 as rt -> no stall; dx=lw r0 -> no stall.
- Blocking multdiv: dx=mult r3, ready pulsed 10 cycles later -> md_start 1 cycle, stall 12 cycles total, md_wb_valid on cycle 11, md_pending_rd=3.
- Non-blocking: mult r3 issued, fd=add r4,r1,r2 -> no stall; then fd=add r6,r3,r1 -> stall until the MD_WB cycle ends; fd=div while busy -> stall.
- Timeout (MD_TIMEOUT=8): issue mult, never pulse ready -> timeout_err=1 eight cycles after md_start, stall held; assert reset -> everything clears.
- Reset mid-op: reset low in MD_BUSY -> outputs cleared asynchronously before the next edge, state IDLE; a late ready pulse is ignored.
- Simultaneous: ready and timeout expiry in the same cycle -> MD_WB, timeout_err stays 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared decode constants, multdiv FSM state type and instruction field slicers
// for the F/D-D/X hazard controller.
package hazard_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned FIELD_W = 5;

  localparam logic [FIELD_W-1:0] OP_RTYPE = 5'b00000;
  localparam logic [FIELD_W-1:0] OP_LW    = 5'b01000;
  localparam logic [FIELD_W-1:0] OP_SW    = 5'b00111;

  localparam logic [FIELD_W-1:0] ALU_MULT = 5'b00110;
  localparam logic [FIELD_W-1:0] ALU_DIV  = 5'b00111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MD_BUSY = 2'd1,
    ST_MD_WB   = 2'd2,
    ST_ERR     = 2'd3
  } md_state_e;

  function automatic logic [FIELD_W-1:0] get_opcode(input logic [INSTR_W-1:0] ir);
    return ir[31:27];
  endfunction

  function automatic logic [FIELD_W-1:0] get_rd(input logic [INSTR_W-1:0] ir);
    return ir[26:22];
  endfunction

  function automatic logic [FIELD_W-1:0] get_rs(input logic [INSTR_W-1:0] ir);
    return ir[21:17];
  endfunction

  function automatic logic [FIELD_W-1:0] get_rt(input logic [INSTR_W-1:0] ir);
    return ir[16:12];
  endfunction

  function automatic logic [FIELD_W-1:0] get_alu_op(input logic [INSTR_W-1:0] ir);
    return ir[6:2];
  endfunction

  // R-type mult or div: the only instructions that occupy the multdiv unit
  function automatic logic is_multdiv(input logic [INSTR_W-1:0] ir);
    return (get_opcode(ir) == OP_RTYPE) &&
           ((get_alu_op(ir) == ALU_MULT) || (get_alu_op(ir) == ALU_DIV));
  endfunction

endpackage

// File: rtl/hazard_md_fsm.sv
// Tracks the single outstanding multdiv op: issue, wait with timeout, one-cycle
// writeback slot, and a sticky error state left only by reset.
module hazard_md_fsm
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W      = 5,
  parameter int unsigned MD_TIMEOUT = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             issue_i,
  input  logic [REG_W-1:0] issue_rd_i,
  input  logic             ready_i,
  output logic             md_start_c,
  output md_state_e        state_o,
  output logic [REG_W-1:0] pending_rd_o,
  output logic             wb_valid_o,
  output logic             timeout_err_o
);

  localparam int unsigned      TMO_W    = $clog2(MD_TIMEOUT) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MD_TIMEOUT - 1);

  md_state_e        state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [REG_W-1:0] pend_q, pend_d;
  logic             wb_q, wb_d;
  logic             err_q, err_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      tmo_q   <= '0;
      pend_q  <= '0;
      wb_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      pend_q  <= pend_d;
      wb_q    <= wb_d;
      err_q   <= err_d;
    end
  end

  // Ready beats timeout when both land in the same busy cycle
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    pend_d     = pend_q;
    md_start_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (issue_i) begin
          md_start_c = reset;
          pend_d     = issue_rd_i;
          tmo_d      = '0;
          state_d    = ST_MD_BUSY;
        end
      end
      ST_MD_BUSY: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (ready_i) begin
          state_d = ST_MD_WB;
        end else if (tmo_d == TMO_LAST) begin
          state_d = ST_ERR;
        end
      end
      ST_MD_WB: state_d = ST_IDLE;
      ST_ERR:   state_d = ST_ERR;
      default:  state_d = ST_IDLE;
    endcase
    wb_d  = (state_d == ST_MD_WB);
    err_d = (state_d == ST_ERR);
  end

  assign state_o       = state_q;
  assign pending_rd_o  = pend_q;
  assign wb_valid_o    = wb_q;
  assign timeout_err_o = err_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard controller between F/D and D/X: load-use bubbles plus a one-deep
// multdiv scoreboard, in blocking or non-blocking issue mode.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W             = 5,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned NONBLOCK_MD       = 0,
  parameter int unsigned MD_TIMEOUT        = 64,
  parameter int unsigned ZERO_REG_EXEMPT   = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [INSTR_W-1:0] fd_ir,
  input  logic [INSTR_W-1:0] dx_ir,
  input  logic               multdiv_result_ready,
  output logic               select_stall,
  output logic               md_start,
  output logic [REG_W-1:0]   md_pending_rd,
  output logic               md_wb_valid,
  output logic               timeout_err
);

  localparam logic [1:0] LD_RELOAD = 2'(LOAD_STALL_CYCLES - 1);

  logic [REG_W-1:0] fd_rd, fd_rs, fd_rt, dx_rd;
  logic             fd_is_sw, fd_is_md, dx_is_lw, dx_is_md;
  logic             load_use_c, load_stall_c, md_dep_c, md_stall_c;
  logic [1:0]       ld_cnt_q, ld_cnt_d;
  md_state_e        md_state;
  logic             unused_ir_bits;

  assign fd_rd    = REG_W'(get_rd(fd_ir));
  assign fd_rs    = REG_W'(get_rs(fd_ir));
  assign fd_rt    = REG_W'(get_rt(fd_ir));
  assign dx_rd    = REG_W'(get_rd(dx_ir));
  assign fd_is_sw = (get_opcode(fd_ir) == OP_SW);
  assign fd_is_md = is_multdiv(fd_ir);
  assign dx_is_lw = (get_opcode(dx_ir) == OP_LW);
  assign dx_is_md = is_multdiv(dx_ir);

  assign unused_ir_bits = ^{fd_ir[11:7], fd_ir[1:0], dx_ir[21:7], dx_ir[1:0]};

  // sw carries its store data in rd, so its rt field is not a source
  assign load_use_c = dx_is_lw &&
                      ((dx_rd != '0) || (ZERO_REG_EXEMPT == 0)) &&
                      ((fd_rs == dx_rd) || ((fd_rt == dx_rd) && !fd_is_sw));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ld_cnt_q <= 2'd0;
    end else begin
      ld_cnt_q <= ld_cnt_d;
    end
  end

  // Remaining bubbles after the hazard cycle; a running count is never reloaded
  always_comb begin
    ld_cnt_d = ld_cnt_q;
    if (ld_cnt_q != 2'd0) begin
      ld_cnt_d = ld_cnt_q - 2'd1;
    end else if (load_use_c) begin
      ld_cnt_d = LD_RELOAD;
    end
  end

  assign load_stall_c = load_use_c || (ld_cnt_q != 2'd0);

  hazard_md_fsm #(
    .REG_W      (REG_W),
    .MD_TIMEOUT (MD_TIMEOUT)
  ) u_md_fsm (
    .clock         (clock),
    .reset         (reset),
    .issue_i       (dx_is_md),
    .issue_rd_i    (dx_rd),
    .ready_i       (multdiv_result_ready),
    .md_start_c    (md_start),
    .state_o       (md_state),
    .pending_rd_o  (md_pending_rd),
    .wb_valid_o    (md_wb_valid),
    .timeout_err_o (timeout_err)
  );

  assign md_dep_c = ((md_pending_rd != '0) || (ZERO_REG_EXEMPT == 0)) &&
                    ((fd_rs == md_pending_rd) || (fd_rt == md_pending_rd) ||
                     (fd_rd == md_pending_rd));

  always_comb begin
    md_stall_c = 1'b0;
    if (NONBLOCK_MD != 0) begin
      md_stall_c = (md_state == ST_MD_WB) || (md_state == ST_ERR) ||
                   ((md_state == ST_MD_BUSY) && (fd_is_md || md_dep_c));
    end else begin
      md_stall_c = dx_is_md || (md_state != ST_IDLE);
    end
  end

  assign select_stall = !reset || load_stall_c || md_stall_c;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Two hazard_scoreboard configurations driven in parallel by directed and random
// instruction streams, checked each cycle against a cycle-level behavioural model.
module tb_hazard_scoreboard;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] fd_ir = '0;
  logic [31:0] dx_ir = '0;
  logic        multdiv_result_ready = 1'b0;

  logic       b_stall, b_start, b_wb, b_err;
  logic [4:0] b_prd;
  logic       n_stall, n_start, n_wb, n_err;
  logic [4:0] n_prd;

  int n_tests = 0;
  int n_fail  = 0;

  logic       pin_b_en = 1'b0;
  logic       pin_n_en = 1'b0;
  logic [8:0] pin_b = '0;
  logic [8:0] pin_n = '0;
  string      pin_name = "";

  // model state per instance: 0 = blocking, 1 = non-blocking
  int bub[2];
  int age[2];
  int pend[2];
  bit wb[2];
  bit err[2];

  always #5 clock = ~clock;

  hazard_scoreboard #(
    .REG_W(5), .LOAD_STALL_CYCLES(2), .NONBLOCK_MD(0), .MD_TIMEOUT(16), .ZERO_REG_EXEMPT(1)
  ) u_blk (
    .clock(clock), .reset(reset), .fd_ir(fd_ir), .dx_ir(dx_ir),
    .multdiv_result_ready(multdiv_result_ready), .select_stall(b_stall), .md_start(b_start),
    .md_pending_rd(b_prd), .md_wb_valid(b_wb), .timeout_err(b_err)
  );

  hazard_scoreboard #(
    .REG_W(5), .LOAD_STALL_CYCLES(3), .NONBLOCK_MD(1), .MD_TIMEOUT(8), .ZERO_REG_EXEMPT(0)
  ) u_nb (
    .clock(clock), .reset(reset), .fd_ir(fd_ir), .dx_ir(dx_ir),
    .multdiv_result_ready(multdiv_result_ready), .select_stall(n_stall), .md_start(n_start),
    .md_pending_rd(n_prd), .md_wb_valid(n_wb), .timeout_err(n_err)
  );

  function automatic int cfg_lsc(input int i); return (i == 0) ? 2 : 3; endfunction
  function automatic int cfg_to(input int i);  return (i == 0) ? 16 : 8; endfunction
  function automatic bit cfg_nb(input int i);  return (i != 0); endfunction
  function automatic bit cfg_zre(input int i); return (i == 0); endfunction

  function automatic int frd(input logic [31:0] x); return int'(x[26:22]); endfunction
  function automatic int frs(input logic [31:0] x); return int'(x[21:17]); endfunction
  function automatic int frt(input logic [31:0] x); return int'(x[16:12]); endfunction
  function automatic bit is_lw(input logic [31:0] x); return x[31:27] == 5'b01000; endfunction
  function automatic bit is_sw(input logic [31:0] x); return x[31:27] == 5'b00111; endfunction
  function automatic bit is_md(input logic [31:0] x);
    return (x[31:27] == 5'b00000) && ((x[6:2] == 5'b00110) || (x[6:2] == 5'b00111));
  endfunction

  function automatic logic [31:0] rtype(input logic [4:0] alu, rd, rs, rt);
    return {5'b00000, rd, rs, rt, 5'b00000, alu, 2'b00};
  endfunction
  function automatic logic [31:0] lw(input logic [4:0] rd, rs);
    return {5'b01000, rd, rs, 17'd0};
  endfunction
  function automatic logic [31:0] sw(input logic [4:0] rd, rs, rt);
    return {5'b00111, rd, rs, rt, 12'd0};
  endfunction

  function automatic logic [8:0] pv(input bit st, input bit sa, input bit w, input bit e, input int p);
    return {st, sa, w, e, 5'(p)};
  endfunction

  function automatic bit load_use(input int i, input logic [31:0] fd, input logic [31:0] dx);
    if (!is_lw(dx)) return 1'b0;
    if ((frd(dx) == 0) && cfg_zre(i)) return 1'b0;
    return (frs(fd) == frd(dx)) || ((frt(fd) == frd(dx)) && !is_sw(fd));
  endfunction

  function automatic logic [8:0] expect_vec(input int i);
    bit idle, busy, dep, stall, start;
    if (!reset) return 9'b1_0000_0000;
    idle  = !err[i] && !wb[i] && (age[i] == 0);
    busy  = (age[i] > 0);
    start = idle && is_md(dx_ir);
    dep   = ((pend[i] != 0) || !cfg_zre(i)) &&
            ((frs(fd_ir) == pend[i]) || (frt(fd_ir) == pend[i]) || (frd(fd_ir) == pend[i]));
    stall = load_use(i, fd_ir, dx_ir) || (bub[i] > 0);
    if (cfg_nb(i)) stall = stall || wb[i] || err[i] || (busy && (is_md(fd_ir) || dep));
    else           stall = stall || is_md(dx_ir) || !idle;
    return pv(stall, start, wb[i], err[i], pend[i]);
  endfunction

  // behavioural model: age counts cycles since md_start while the op is outstanding
  always @(posedge clock or negedge reset) begin : model
    bit lu;
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        bub[i] = 0; age[i] = 0; pend[i] = 0; wb[i] = 1'b0; err[i] = 1'b0;
      end else begin
        lu = load_use(i, fd_ir, dx_ir);
        if (bub[i] > 0) bub[i] = bub[i] - 1;
        else if (lu)    bub[i] = cfg_lsc(i) - 1;
        if (err[i]) begin
          err[i] = 1'b1;
        end else if (wb[i]) begin
          wb[i] = 1'b0;
        end else if (age[i] > 0) begin
          if (multdiv_result_ready)         begin wb[i] = 1'b1;  age[i] = 0; end
          else if (age[i] == cfg_to(i) - 1) begin err[i] = 1'b1; age[i] = 0; end
          else age[i] = age[i] + 1;
        end else if (is_md(dx_ir)) begin
          age[i]  = 1;
          pend[i] = frd(dx_ir);
        end
      end
    end
  end

  always @(negedge clock) begin : cmp
    logic [8:0] g;
    logic [8:0] e;
    for (int i = 0; i < 2; i++) begin
      g = (i == 0) ? {b_stall, b_start, b_wb, b_err, b_prd} : {n_stall, n_start, n_wb, n_err, n_prd};
      e = expect_vec(i);
      n_tests++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL model[%0d] t=%0t stall/start/wb/err/prd got %b required %b", i, $time, g, e);
      end
    end
    if (pin_b_en) begin
      n_tests++;
      if ({b_stall, b_start, b_wb, b_err, b_prd} !== pin_b) begin
        n_fail++;
        $display("FAIL %s blk got %b required %b", pin_name, {b_stall, b_start, b_wb, b_err, b_prd}, pin_b);
      end
    end
    if (pin_n_en) begin
      n_tests++;
      if ({n_stall, n_start, n_wb, n_err, n_prd} !== pin_n) begin
        n_fail++;
        $display("FAIL %s nb got %b required %b", pin_name, {n_stall, n_start, n_wb, n_err, n_prd}, pin_n);
      end
    end
  end

  task automatic step(input logic [31:0] fd, input logic [31:0] dx, input logic r, input logic rn,
                      input logic pbe, input logic [8:0] pbv, input logic pne, input logic [8:0] pnv,
                      input string nm);
    @(posedge clock);
    #1;
    fd_ir = fd; dx_ir = dx; multdiv_result_ready = r; reset = rn;
    pin_b_en = pbe; pin_b = pbv; pin_n_en = pne; pin_n = pnv; pin_name = nm;
    @(negedge clock);
    #1;
    pin_b_en = 1'b0; pin_n_en = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] a, b, c;
    a = 5'($urandom_range(0, 7));
    b = 5'($urandom_range(0, 7));
    c = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 7))
      0, 1:    return lw(a, b);
      2:       return sw(a, b, c);
      3:       return rtype(5'($urandom_range(0, 5)), a, b, c);
      4:       return rtype(5'b00110, a, b, c);
      5:       return rtype(5'b00111, a, b, c);
      6:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] nop, add4, add6, add1, mul3, div7, div8, mul9;
    nop  = 32'h0;
    add4 = rtype(5'd0, 5'd4, 5'd1, 5'd2);
    add6 = rtype(5'd0, 5'd6, 5'd3, 5'd1);
    add1 = rtype(5'd0, 5'd1, 5'd5, 5'd2);
    mul3 = rtype(5'b00110, 5'd3, 5'd1, 5'd2);
    div7 = rtype(5'b00111, 5'd7, 5'd1, 5'd2);
    div8 = rtype(5'b00111, 5'd8, 5'd1, 5'd2);
    mul9 = rtype(5'b00110, 5'd9, 5'd1, 5'd2);

    step(nop, nop, 0, 0, 1, pv(1,0,0,0,0), 1, pv(1,0,0,0,0), "reset_hold");
    step(nop, nop, 0, 0, 1, pv(1,0,0,0,0), 1, pv(1,0,0,0,0), "reset_hold2");

    // load-use: 2 bubbles (blk), 3 bubbles (nb)
    step(add1, lw(5'd5, 5'd1), 0, 1, 1, pv(1,0,0,0,0), 1, pv(1,0,0,0,0), "lu_hit");
    step(add1, nop, 0, 1, 1, pv(1,0,0,0,0), 1, pv(1,0,0,0,0), "lu_bubble2");
    step(add1, nop, 0, 1, 1, pv(0,0,0,0,0), 1, pv(1,0,0,0,0), "lu_bubble3");
    step(nop, nop, 0, 1, 1, pv(0,0,0,0,0), 1, pv(0,0,0,0,0), "lu_done");
    step(sw(5'd1, 5'd2, 5'd5), lw(5'd5, 5'd1), 0, 1, 1, pv(0,0,0,0,0), 1, pv(0,0,0,0,0), "lu_sw_rt");
    step(rtype(5'd0, 5'd1, 5'd0, 5'd0), lw(5'd0, 5'd1), 0, 1, 1, pv(0,0,0,0,0), 1, pv(1,0,0,0,0), "lu_r0");
    for (int k = 0; k < 4; k++) step(nop, nop, 0, 1, 0, '0, 0, '0, "");

    // blocking op, ready 10 cycles after issue; nb times out at cycle 8
    step(add4, mul3, 0, 1, 1, pv(1,1,0,0,0), 1, pv(0,1,0,0,0), "md_issue");
    for (int k = 1; k <= 7; k++) step(add4, nop, 0, 1, 1, pv(1,0,0,0,3), 1, pv(0,0,0,0,3), "md_busy");
    step(add4, nop, 0, 1, 1, pv(1,0,0,0,3), 1, pv(1,0,0,1,3), "md_timeout8");
    step(add4, nop, 0, 1, 1, pv(1,0,0,0,3), 1, pv(1,0,0,1,3), "md_err_hold");
    step(add4, nop, 1, 1, 1, pv(1,0,0,0,3), 1, pv(1,0,0,1,3), "md_ready10");
    step(add4, nop, 0, 1, 1, pv(1,0,1,0,3), 1, pv(1,0,0,1,3), "md_wb11");
    step(add4, nop, 0, 1, 1, pv(0,0,0,0,3), 1, pv(1,0,0,1,3), "md_idle12");
    step(nop, nop, 0, 0, 1, pv(1,0,0,0,0), 1, pv(1,0,0,0,0), "err_reset");

    // non-blocking dependences, then ready and timeout in the same cycle
    step(add4, mul3, 0, 1, 1, pv(1,1,0,0,0), 1, pv(0,1,0,0,0), "nb_issue");
    step(add6, add4, 0, 1, 1, pv(1,0,0,0,3), 1, pv(1,0,0,0,3), "nb_raw");
    step(add6, nop, 0, 1, 1, pv(1,0,0,0,3), 1, pv(1,0,0,0,3), "nb_raw2");
    step(add6, nop, 1, 1, 1, pv(1,0,0,0,3), 1, pv(1,0,0,0,3), "nb_ready");
    step(add6, nop, 0, 1, 1, pv(1,0,1,0,3), 1, pv(1,0,1,0,3), "nb_wb");
    step(add6, nop, 0, 1, 1, pv(0,0,0,0,3), 1, pv(0,0,0,0,3), "nb_release");
    step(nop, div7, 0, 1, 1, pv(1,1,0,0,3), 1, pv(0,1,0,0,3), "nb_issue_div");
    for (int k = 1; k <= 6; k++) step(div8, nop, 0, 1, 1, pv(1,0,0,0,7), 1, pv(1,0,0,0,7), "nb_fd_md");
    step(div8, nop, 1, 1, 1, pv(1,0,0,0,7), 1, pv(1,0,0,0,7), "sim_ready_tmo");
    step(div8, nop, 0, 1, 1, pv(1,0,1,0,7), 1, pv(1,0,1,0,7), "sim_wb_no_err");
    step(nop, nop, 0, 1, 1, pv(0,0,0,0,7), 1, pv(0,0,0,0,7), "sim_idle");

    // reset in the middle of an op, then a stale ready
    step(nop, mul9, 0, 1, 1, pv(1,1,0,0,7), 1, pv(0,1,0,0,7), "rst_issue");
    step(nop, nop, 0, 1, 1, pv(1,0,0,0,9), 1, pv(0,0,0,0,9), "rst_busy");
    step(nop, nop, 0, 1, 1, pv(1,0,0,0,9), 1, pv(0,0,0,0,9), "rst_busy2");
    step(nop, nop, 0, 0, 1, pv(1,0,0,0,0), 1, pv(1,0,0,0,0), "rst_async");
    step(nop, nop, 1, 1, 1, pv(0,0,0,0,0), 1, pv(0,0,0,0,0), "rst_late_ready");
    step(nop, nop, 0, 1, 1, pv(0,0,0,0,0), 1, pv(0,0,0,0,0), "rst_no_wb");

    // random traffic: alternating chatty and sparse ready to reach timeouts
    for (int c = 0; c < 3000; c++) begin
      int unsigned p;
      logic rn;
      p  = (((c / 400) % 2) == 0) ? 25 : 2;
      rn = ($urandom_range(0, 299) != 0);
      step(rand_instr(), rand_instr(), ($urandom_range(0, 99) < p), rn, 0, '0, 0, '0, "");
    end

    @(posedge clock);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
